// File: rtl/sprite_pkg.sv
// Shared encodings and helpers for the sprite motion controller.
// Holds state and sprite ROM encodings plus the default placement constants.
package sprite_pkg;

    typedef enum logic [2:0] {
        STAND  = 3'd0,
        RUN    = 3'd1,
        JUMP   = 3'd2,
        CROUCH = 3'd3
    } motion_state_e;

    localparam logic [3:0] RUN0      = 4'd0;
    localparam logic [3:0] RUN1      = 4'd1;
    localparam logic [3:0] RUN2      = 4'd2;
    localparam logic [3:0] JUMP_ID   = 4'd3;
    localparam logic [3:0] CROUCH_ID = 4'd4;

    localparam int DEFAULT_FLOOR_Y = 20;
    localparam int DEFAULT_X_POS   = 95;

    // Screen y of the sprite; clamps to the largest positive 10-bit value.
    function automatic logic signed [9:0] floor_plus_height(input int floor_y,
                                                            input logic [8:0] height);
        int s;
        s = floor_y + int'(height);
        if (s > 511) begin
            return 10'sd511;
        end
        return $signed(10'(s));
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-clock game tick every DIV clocks.
module tick_prescaler #(
    parameter int DIV = 833333
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_count;

    assign tick = (r_count == CW'(DIV - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/sprite_motion_controller.sv
// Player sprite state machine with jump physics; position updates are held off
// while the display is reading the sprite registers.
module sprite_motion_controller
    import sprite_pkg::*;
#(
    parameter int CLOCK_FREQ    = 50000000,
    parameter int TICK_RATE     = 60,
    parameter int ANIM_DIV      = 6,
    parameter int X_POS         = DEFAULT_X_POS,
    parameter int FLOOR_Y       = DEFAULT_FLOOR_Y,
    parameter int JUMP_VELOCITY = 12,
    parameter int GRAVITY       = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [3:0]        keys,
    input  logic              drawBusy,
    output logic signed [8:0] xSprite,
    output logic signed [9:0] ySprite,
    output logic [3:0]        spriteId,
    output logic              updated,
    output logic [2:0]        motionState
);

    logic w_tick;
    logic w_update;
    logic signed [9:0] w_sum;
    logic w_land;
    logic [8:0] w_height_nx;

    motion_state_e     r_state;
    logic              r_pending;
    logic [8:0]        r_height;
    logic signed [7:0] r_velocity;
    logic [7:0]        r_anim;
    logic [3:0]        r_sprite_id;
    logic signed [9:0] r_y;
    logic              r_updated;

    tick_prescaler #(
        .DIV(CLOCK_FREQ / TICK_RATE)
    ) u_prescaler (
        .clock(clock),
        .reset(reset),
        .tick (w_tick)
    );

    // A pending tick fires on the first cycle the display lets go.
    assign w_update = (w_tick | r_pending) & ~drawBusy;

    always_comb begin
        w_sum       = $signed({1'b0, r_height}) + $signed({{2{r_velocity[7]}}, r_velocity});
        w_land      = (w_sum <= 10'sd0);
        w_height_nx = r_height;
        if (r_state == JUMP) begin
            w_height_nx = w_land ? 9'd0 : w_sum[8:0];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= STAND;
            r_pending   <= 1'b0;
            r_height    <= '0;
            r_velocity  <= '0;
            r_anim      <= '0;
            r_sprite_id <= RUN0;
            r_y         <= floor_plus_height(FLOOR_Y, 9'd0);
            r_updated   <= 1'b0;
        end else begin
            r_updated <= w_update;
            if (w_update) begin
                r_pending <= 1'b0;
            end else if (w_tick) begin
                r_pending <= 1'b1;
            end

            if (w_update) begin
                r_height <= w_height_nx;
                r_y      <= floor_plus_height(FLOOR_Y, w_height_nx);
                case (r_state)
                    STAND: begin
                        r_sprite_id <= RUN0;
                        if (!keys[2]) begin
                            r_state <= RUN;
                            r_anim  <= '0;
                        end
                    end
                    RUN: begin
                        if (!keys[3]) begin
                            r_state     <= STAND;
                            r_sprite_id <= RUN0;
                        end else if (!keys[0]) begin
                            r_state     <= JUMP;
                            r_velocity  <= 8'(JUMP_VELOCITY);
                            r_sprite_id <= JUMP_ID;
                        end else if (!keys[1]) begin
                            r_state     <= CROUCH;
                            r_sprite_id <= CROUCH_ID;
                        end else if (r_anim == 8'(ANIM_DIV - 1)) begin
                            r_anim      <= '0;
                            r_sprite_id <= (r_sprite_id == RUN2) ? RUN0 : r_sprite_id + 4'd1;
                        end else begin
                            r_anim <= r_anim + 8'd1;
                        end
                    end
                    JUMP: begin
                        if (w_land) begin
                            r_velocity <= '0;
                            if (!keys[1]) begin
                                r_state     <= CROUCH;
                                r_sprite_id <= CROUCH_ID;
                            end else begin
                                r_state     <= RUN;
                                r_sprite_id <= RUN0;
                                r_anim      <= '0;
                            end
                        end else begin
                            r_velocity  <= r_velocity - 8'(GRAVITY);
                            r_sprite_id <= JUMP_ID;
                        end
                    end
                    CROUCH: begin
                        if (keys[1]) begin
                            r_state     <= RUN;
                            r_sprite_id <= RUN0;
                            r_anim      <= '0;
                        end else begin
                            r_sprite_id <= CROUCH_ID;
                        end
                    end
                    default: r_state <= STAND;
                endcase
            end
        end
    end

    assign xSprite     = $signed(9'(X_POS));
    assign ySprite     = r_y;
    assign spriteId    = r_sprite_id;
    assign updated     = r_updated;
    assign motionState = r_state;

endmodule

// File: tb/tb_sprite_motion_controller.sv
// Directed bench for sprite_motion_controller with a 10-clock game tick.
module tb_sprite_motion_controller;

    logic              clock = 1'b0;
    logic              reset;
    logic [3:0]        keys;
    logic              drawBusy;
    logic signed [8:0] xSprite;
    logic signed [9:0] ySprite;
    logic [3:0]        spriteId;
    logic              updated;
    logic [2:0]        motionState;

    int checks   = 0;
    int failures = 0;

    localparam int ST_STAND  = 0;
    localparam int ST_RUN    = 1;
    localparam int ST_JUMP   = 2;
    localparam int ST_CROUCH = 3;

    sprite_motion_controller #(
        .CLOCK_FREQ(100),
        .TICK_RATE (10)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .keys       (keys),
        .drawBusy   (drawBusy),
        .xSprite    (xSprite),
        .ySprite    (ySprite),
        .spriteId   (spriteId),
        .updated    (updated),
        .motionState(motionState)
    );

    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to the negedge where the updated pulse is visible.
    task automatic next_update(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 25 && !seen; i++) begin
            @(negedge clock);
            seen = updated;
        end
        check_eq({tag, "_seen"}, int'(seen), 1);
    endtask

    task automatic expect_out(input string tag, input int st, input int y, input int id);
        check_eq({tag, "_state"}, int'(motionState), st);
        check_eq({tag, "_y"}, int'(ySprite), y);
        check_eq({tag, "_id"}, int'(spriteId), id);
    endtask

    int jump_y[25] = '{32, 43, 53, 62, 70, 77, 83, 88, 92, 95, 97, 98, 98,
                       97, 95, 92, 88, 83, 77, 70, 62, 53, 43, 32, 20};

    initial begin
        int n_upd;
        bit quiet;

        reset    = 1'b1;
        keys     = 4'hF;
        drawBusy = 1'b0;
        repeat (3) @(negedge clock);
        expect_out("rst", ST_STAND, 20, 0);
        check_eq("rst_x", int'(xSprite), 95);
        check_eq("rst_upd", int'(updated), 0);
        reset = 1'b0;

        // Idle in STAND: updates pulse without changing outputs.
        for (int i = 0; i < 2; i++) begin
            next_update("stand");
            expect_out("stand", ST_STAND, 20, 0);
        end
        @(negedge clock);
        check_eq("upd_one_clk", int'(updated), 0);

        keys = 4'hB;
        next_update("start");
        expect_out("start", ST_RUN, 20, 0);
        keys = 4'hF;
        for (int k = 1; k <= 18; k++) begin
            next_update("anim");
            check_eq($sformatf("anim%0d_id", k), int'(spriteId), (k / 6) % 3);
        end
        check_eq("anim_state", int'(motionState), ST_RUN);

        keys = 4'hE;
        next_update("jstart");
        expect_out("jstart", ST_JUMP, 20, 3);
        keys = 4'hF;
        for (int k = 1; k <= 25; k++) begin
            next_update("jump");
            check_eq($sformatf("jump%0d_y", k), int'(ySprite), jump_y[k-1]);
            if (k < 25) begin
                check_eq($sformatf("jump%0d_id", k), int'(spriteId), 3);
                check_eq($sformatf("jump%0d_st", k), int'(motionState), ST_JUMP);
            end
        end
        expect_out("land", ST_RUN, 20, 0);

        // Hold the display busy across three ticks.
        drawBusy = 1'b1;
        quiet    = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(negedge clock);
            if (updated || spriteId != 4'd0 || ySprite != 10'sd20 || motionState != 3'd1) begin
                quiet = 1'b0;
            end
        end
        check_eq("defer_quiet", int'(quiet), 1);
        drawBusy = 1'b0;
        @(negedge clock);
        check_eq("defer_fire", int'(updated), 1);
        n_upd = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_upd += int'(updated);
        end
        check_eq("defer_single", n_upd, 0);
        expect_out("defer", ST_RUN, 20, 0);

        keys = 4'hD;
        next_update("crouch");
        expect_out("crouch", ST_CROUCH, 20, 4);
        keys = 4'hC;
        next_update("crouch_jump");
        expect_out("crouch_jump", ST_CROUCH, 20, 4);
        keys = 4'hF;
        next_update("uncrouch");
        expect_out("uncrouch", ST_RUN, 20, 0);

        keys = 4'h7;
        next_update("stop");
        expect_out("stop", ST_STAND, 20, 0);
        keys = 4'hB;
        next_update("restart");
        expect_out("restart", ST_RUN, 20, 0);

        // Reset in the middle of a jump.
        keys = 4'hE;
        next_update("j2start");
        keys = 4'hF;
        for (int k = 1; k <= 7; k++) begin
            next_update("j2");
        end
        expect_out("j2_7", ST_JUMP, 83, 3);
        #1 reset = 1'b1;
        #1;
        expect_out("rst_mid", ST_STAND, 20, 0);
        check_eq("rst_mid_upd", int'(updated), 0);
        repeat (12) @(negedge clock);
        check_eq("rst_hold_upd", int'(updated), 0);
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
